// File: rtl/regfile_sb.sv
// Register file for the ID stage with per-register pending bits and a post-reset clear sweep.
// Build with REGFILE_BYPASS_EN defined to forward same-cycle writeback data onto the read ports.
module regfile_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int AW = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            ready,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rs1_v,
   output logic [XLEN-1:0] rs2_v,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            issue_en,
   input  logic [AW-1:0]   issue_rd,
   input  logic            wen,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] rd_v
);

   typedef enum logic {INIT, RUN} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [AW-1:0]     clr_idx;
   logic [XLEN-1:0]   regs [NREG];
   logic [NREG-1:0]   pend;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    if (clr_idx == AW'(NREG - 1)) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = INIT;
      endcase
   end

   // The sweep index wraps to 0 exactly as the last entry clears.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clr_idx <= '0;
      end else if (state == INIT) begin
         clr_idx <= clr_idx + 1'b1;
      end
   end

   // The array itself has no reset; the sweep zeroes it one entry per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (state == INIT) begin
            regs[clr_idx] <= '0;
         end else if (wen && rd != '0) begin
            regs[rd] <= rd_v;
         end
      end
   end

   // Issue is applied after writeback so a newer producer keeps the bit set.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pend <= '0;
      end else if (state == RUN) begin
         if (wen && rd != '0) begin
            pend[rd] <= 1'b0;
         end
         if (issue_en && issue_rd != '0) begin
            pend[issue_rd] <= 1'b1;
         end
      end
   end

   always_comb begin
      ready    = (state == RUN);
      rs1_v    = '0;
      rs2_v    = '0;
      rs1_busy = 1'b0;
      rs2_busy = 1'b0;
      if (state == RUN) begin
         if (rs1 != '0) begin
            rs1_v    = regs[rs1];
            rs1_busy = pend[rs1];
         end
         if (rs2 != '0) begin
            rs2_v    = regs[rs2];
            rs2_busy = pend[rs2];
         end
`ifdef REGFILE_BYPASS_EN
         if (wen && rd != '0 && rd == rs1) begin
            rs1_v    = rd_v;
            rs1_busy = 1'b0;
         end
         if (wen && rd != '0 && rd == rs2) begin
            rs2_v    = rd_v;
            rs2_busy = 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset sweep, mid-sweep reset, read/write, bypass and scoreboard behaviour.
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = $clog2(NREG);

   logic            clk;
   logic            rst;
   logic            ready;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [XLEN-1:0] rs1_v;
   logic [XLEN-1:0] rs2_v;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            issue_en;
   logic [AW-1:0]   issue_rd;
   logic            wen;
   logic [AW-1:0]   rd;
   logic [XLEN-1:0] rd_v;

   int n_cmp = 0;
   int n_err = 0;

   regfile_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready),
      .rs1      (rs1),
      .rs2      (rs2),
      .rs1_v    (rs1_v),
      .rs2_v    (rs2_v),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .issue_en (issue_en),
      .issue_rd (issue_rd),
      .wen      (wen),
      .rd       (rd),
      .rd_v     (rd_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_err++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      rst      = 1'b0;
      rs1      = 5'd5;
      rs2      = 5'd6;
      issue_en = 1'b0;
      issue_rd = '0;
      wen      = 1'b0;
      rd       = '0;
      rd_v     = '0;

      // Reset held for three edges, then a full sweep.
      repeat (3) tick();
      check_output("rst_ready", 32'(ready), 32'd0);
      check_output("rst_rs1_v", rs1_v, 32'd0);
      check_output("rst_rs2_v", rs2_v, 32'd0);
      check_output("rst_rs1_busy", 32'(rs1_busy), 32'd0);
      check_output("rst_rs2_busy", 32'(rs2_busy), 32'd0);

      rst = 1'b1;
      #1;
      check_output("sweep_ready_e0", 32'(ready), 32'd0);
      for (int i = 1; i < NREG; i++) begin
         tick();
         check_output($sformatf("sweep_ready_e%0d", i), 32'(ready), 32'd0);
      end
      tick();
      check_output("sweep_ready_done", 32'(ready), 32'd1);
      for (int i = 0; i < NREG; i++) begin
         rs1 = AW'(i);
         rs2 = AW'(NREG - 1 - i);
         #1;
         check_output($sformatf("sweep_zero_rs1_x%0d", i), rs1_v, 32'd0);
         check_output($sformatf("sweep_zero_rs2_x%0d", NREG - 1 - i), rs2_v, 32'd0);
      end

      // Put data in x5 so a missing clear would be visible later.
      wen  = 1'b1;
      rd   = 5'd5;
      rd_v = 32'hCAFE_0005;
      tick();
      wen  = 1'b0;
      rs1  = 5'd5;
      #1;
      check_output("pre_mid_x5", rs1_v, 32'hCAFE_0005);

      // Reset mid-sweep, with writes attempted throughout the second sweep.
      rst = 1'b0;
      tick();
      check_output("mid_rst_ready", 32'(ready), 32'd0);
      rst = 1'b1;
      repeat (10) tick();
      check_output("mid_ready_e10", 32'(ready), 32'd0);
      rst  = 1'b0;
      tick();
      rst  = 1'b1;
      wen  = 1'b1;
      rd   = 5'd5;
      rd_v = 32'hBAD0_BAD0;
      issue_en = 1'b1;
      issue_rd = 5'd5;
      for (int i = 1; i < NREG; i++) begin
         tick();
         if (i == 20) begin
            wen      = 1'b0;
            issue_en = 1'b0;
         end
         check_output($sformatf("mid_ready_e%0d", i), 32'(ready), 32'd0);
         check_output($sformatf("mid_rs1_v_e%0d", i), rs1_v, 32'd0);
      end
      tick();
      check_output("mid_ready_done", 32'(ready), 32'd1);
      rs1 = 5'd5;
      #1;
      check_output("mid_x5_cleared", rs1_v, 32'd0);
      check_output("mid_x5_not_busy", 32'(rs1_busy), 32'd0);

      // Plain write then read.
      wen  = 1'b1;
      rd   = 5'd7;
      rd_v = 32'hDEAD_BEEF;
      tick();
      wen  = 1'b0;
      rs1  = 5'd7;
      #1;
      check_output("wr_x7", rs1_v, 32'hDEAD_BEEF);
      wen  = 1'b1;
      rd   = 5'd0;
      rd_v = 32'h0000_1234;
      tick();
      wen  = 1'b0;
      rs2  = 5'd0;
      #1;
      check_output("wr_x0_v", rs2_v, 32'd0);
      check_output("wr_x0_busy", 32'(rs2_busy), 32'd0);

      // Same-cycle writeback and read of x3, which is pending.
      issue_en = 1'b1;
      issue_rd = 5'd3;
      tick();
      issue_en = 1'b0;
      rs1  = 5'd3;
      #1;
      check_output("x3_pending", 32'(rs1_busy), 32'd1);
      wen  = 1'b1;
      rd   = 5'd3;
      rd_v = 32'hA5A5_A5A5;
      #1;
`ifdef REGFILE_BYPASS_EN
      check_output("bypass_x3_v", rs1_v, 32'hA5A5_A5A5);
      check_output("bypass_x3_busy", 32'(rs1_busy), 32'd0);
`else
      check_output("nobypass_x3_v", rs1_v, 32'd0);
      check_output("nobypass_x3_busy", 32'(rs1_busy), 32'd1);
`endif
      tick();
      wen = 1'b0;
      #1;
      check_output("after_wb_x3_v", rs1_v, 32'hA5A5_A5A5);
      check_output("after_wb_x3_busy", 32'(rs1_busy), 32'd0);

      // Scoreboard on x9; busy has no same-cycle bypass.
      issue_en = 1'b1;
      issue_rd = 5'd9;
      rs2      = 5'd9;
      #1;
      check_output("issue_x9_same_cycle", 32'(rs2_busy), 32'd0);
      tick();
      issue_en = 1'b0;
      #1;
      check_output("issue_x9_busy", 32'(rs2_busy), 32'd1);
      wen  = 1'b1;
      rd   = 5'd9;
      rd_v = 32'h0000_0055;
      tick();
      wen  = 1'b0;
      #1;
      check_output("wb_x9_busy", 32'(rs2_busy), 32'd0);
      check_output("wb_x9_v", rs2_v, 32'h0000_0055);
      issue_en = 1'b1;
      issue_rd = 5'd0;
      tick();
      issue_en = 1'b0;
      rs2      = 5'd0;
      #1;
      check_output("issue_x0_busy", 32'(rs2_busy), 32'd0);
      check_output("issue_x0_v", rs2_v, 32'd0);

      // Issue and writeback to x4 in the same cycle.
      issue_en = 1'b1;
      issue_rd = 5'd4;
      wen      = 1'b1;
      rd       = 5'd4;
      rd_v     = 32'h0000_0077;
      tick();
      issue_en = 1'b0;
      wen      = 1'b0;
      rs1      = 5'd4;
      rs2      = 5'd7;
      #1;
      check_output("collide_x4_v", rs1_v, 32'h0000_0077);
      check_output("collide_x4_busy", 32'(rs1_busy), 32'd1);
      check_output("collide_x7_untouched", rs2_v, 32'hDEAD_BEEF);

      // Writeback to a non-pending register is still a data write.
      wen  = 1'b1;
      rd   = 5'd7;
      rd_v = 32'h0000_0011;
      tick();
      wen  = 1'b0;
      #1;
      check_output("wb_idle_x7_v", rs2_v, 32'h0000_0011);
      check_output("wb_idle_x7_busy", 32'(rs2_busy), 32'd0);
      check_output("x4_still_busy", 32'(rs1_busy), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
